// File: rtl/rvj1_dram_arbiter.sv
// Shares the single 1RW data SRAM between the core data port and the Wishbone slave.
// Contention is fixed core priority, or round-robin when RVJ1_DRAM_RR_EN is defined.
module rvj1_dram_arbiter #(
  parameter int ADDR_W = 9
) (
  input  logic              wb_clk_i,
  input  logic              rstn_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [3:0]        core_be_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              dram_csb0,
  output logic              dram_web0,
  output logic [3:0]        dram_wmask0,
  output logic [ADDR_W-1:0] dram_addr0,
  output logic [31:0]       dram_din0,
  input  logic [31:0]       dram_dout0
);

  typedef enum logic {WB_IDLE, WB_ACK} wb_state_t;

  wb_state_t wb_state;
  logic      core_rvalid_q;
  logic      core_rd_q;
  logic      wb_rd_q;
  logic      core_req;
  logic      wb_req;
  logic      grant_core;
  logic      grant_wb;
  logic      unused_adr_bits;

  assign unused_adr_bits = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

  // Requests are masked during reset so the macro is deselected immediately.
  assign core_req = core_req_i & rstn_i;
  assign wb_req   = wbs_cyc_i & wbs_stb_i & (wb_state == WB_IDLE) & rstn_i;

`ifdef RVJ1_DRAM_RR_EN
  logic last_wb;

  always_comb begin
    grant_wb   = wb_req & (~core_req | ~last_wb);
    grant_core = core_req & ~grant_wb;
  end
`else
  always_comb begin
    grant_core = core_req;
    grant_wb   = wb_req & ~core_req;
  end
`endif

  always_comb begin
    dram_csb0   = 1'b1;
    dram_web0   = 1'b1;
    dram_wmask0 = 4'h0;
    dram_addr0  = '0;
    dram_din0   = 32'h0;
    if (grant_core) begin
      dram_csb0   = 1'b0;
      dram_web0   = ~core_we_i;
      dram_wmask0 = core_we_i ? core_be_i : 4'h0;
      dram_addr0  = core_addr_i;
      dram_din0   = core_wdata_i;
    end else if (grant_wb) begin
      dram_csb0   = 1'b0;
      dram_web0   = ~wbs_we_i;
      dram_wmask0 = wbs_we_i ? wbs_sel_i : 4'h0;
      dram_addr0  = wbs_adr_i[ADDR_W+1:2];
      dram_din0   = wbs_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wb_state      <= WB_IDLE;
      wb_rd_q       <= 1'b0;
      core_rvalid_q <= 1'b0;
      core_rd_q     <= 1'b0;
    end else begin
      core_rvalid_q <= grant_core;
      core_rd_q     <= grant_core & ~core_we_i;
      case (wb_state)
        WB_IDLE: begin
          if (grant_wb) begin
            wb_state <= WB_ACK;
            wb_rd_q  <= ~wbs_we_i;
          end
        end
        // The access was already issued, so the ack completes even if cyc drops.
        WB_ACK:  wb_state <= WB_IDLE;
        default: wb_state <= WB_IDLE;
      endcase
    end
  end

`ifdef RVJ1_DRAM_RR_EN
  always_ff @(posedge wb_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_wb <= 1'b0;
    end else if (core_req & wb_req) begin
      last_wb <= grant_wb;
    end
  end
`endif

  assign core_gnt_o    = grant_core;
  assign core_rvalid_o = core_rvalid_q;
  assign core_rdata_o  = (core_rvalid_q & core_rd_q) ? dram_dout0 : 32'h0;
  assign wbs_ack_o     = (wb_state == WB_ACK);
  assign wbs_dat_o     = ((wb_state == WB_ACK) & wb_rd_q) ? dram_dout0 : 32'h0;

endmodule

// File: tb/tb_rvj1_dram_arbiter.sv
// Bench for rvj1_dram_arbiter: directed scenarios plus a randomized run against a word-array model.
module tb_rvj1_dram_arbiter;

  bit          clk = 1'b0;
  logic        rstn;
  logic        core_req, core_we;
  logic [3:0]  core_be;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic        core_gnt, core_rvalid;
  logic [31:0] core_rdata;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr, wbs_dat_w;
  logic        wbs_ack;
  logic [31:0] wbs_dat_r;
  logic        dram_csb0, dram_web0;
  logic [3:0]  dram_wmask0;
  logic [8:0]  dram_addr0;
  logic [31:0] dram_din0;
  logic [31:0] dram_dout0 = 32'h0;

  bit [31:0] sram_mem [512];
  bit [31:0] ref_mem  [512];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rvj1_dram_arbiter #(.ADDR_W(9)) dut (
    .wb_clk_i(clk), .rstn_i(rstn),
    .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we), .wbs_sel_i(wbs_sel),
    .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat_w), .wbs_ack_o(wbs_ack), .wbs_dat_o(wbs_dat_r),
    .dram_csb0(dram_csb0), .dram_web0(dram_web0), .dram_wmask0(dram_wmask0),
    .dram_addr0(dram_addr0), .dram_din0(dram_din0), .dram_dout0(dram_dout0)
  );

  // 1RW macro: masked write or registered read, one-cycle latency.
  always @(posedge clk) begin
    if (!dram_csb0) begin
      if (!dram_web0) begin
        for (int b = 0; b < 4; b++)
          if (dram_wmask0[b]) sram_mem[dram_addr0][b*8 +: 8] <= dram_din0[b*8 +: 8];
      end else begin
        dram_dout0 <= sram_mem[dram_addr0];
      end
    end
  end

  task automatic ref_write(input logic [8:0] a, input logic [3:0] m, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic clear_inputs();
    core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = 0; wbs_adr = 0; wbs_dat_w = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  task automatic test_reset();
    rstn = 0;
    core_req = 1; core_we = 1; core_be = 4'hF; core_addr = 9'h1A5; core_wdata = 32'h12345678;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'hF; wbs_adr = 32'h40; wbs_dat_w = 32'h9;
    @(negedge clk);
    n_checks++;
    if ({dram_csb0, dram_web0, dram_wmask0, dram_addr0, dram_din0} !== {1'b1, 1'b1, 4'h0, 9'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset_dram: got csb=%b web=%b mask=%h addr=%h din=%h want 1 1 0 0 0",
                         dram_csb0, dram_web0, dram_wmask0, dram_addr0, dram_din0);
    end
    n_checks++;
    if ({core_gnt, core_rvalid, wbs_ack} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got gnt=%b rvalid=%b ack=%b want 0 0 0", core_gnt, core_rvalid, wbs_ack);
    end
    n_checks++;
    if ({core_rdata, wbs_dat_r} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got rdata=%h wbdat=%h want 0 0", core_rdata, wbs_dat_r);
    end
    clear_inputs();
    next_cycle();
    rstn = 1;
    next_cycle();
  endtask

  task automatic test_core_write_read();
    core_req = 1; core_we = 1; core_be = 4'hF; core_addr = 9'h05; core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, core_rvalid, dram_csb0, dram_web0, dram_wmask0, dram_addr0, dram_din0} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 9'h05, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL core_wr_issue: got gnt=%b rv=%b csb=%b web=%b mask=%h addr=%h din=%h",
                         core_gnt, core_rvalid, dram_csb0, dram_web0, dram_wmask0, dram_addr0, dram_din0);
    end
    ref_write(9'h05, 4'hF, 32'hDEADBEEF);
    next_cycle();
    core_we = 0; core_wdata = 0;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, core_rvalid, core_rdata, dram_csb0, dram_web0, dram_wmask0} !==
        {1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 4'h0}) begin
      n_fail++; $display("FAIL core_rd_issue: got gnt=%b rv=%b rdata=%h csb=%b web=%b mask=%h want 1 1 0 0 1 0",
                         core_gnt, core_rvalid, core_rdata, dram_csb0, dram_web0, dram_wmask0);
    end
    next_cycle();
    core_req = 0;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, core_rvalid, core_rdata, dram_csb0} !== {1'b0, 1'b1, 32'hDEADBEEF, 1'b1}) begin
      n_fail++; $display("FAIL core_rd_data: got gnt=%b rv=%b rdata=%h csb=%b want 0 1 deadbeef 1",
                         core_gnt, core_rvalid, core_rdata, dram_csb0);
    end
    next_cycle();
  endtask

  task automatic test_wb_byte_write();
    core_req = 1; core_we = 1; core_be = 4'hF; core_addr = 9'h05; core_wdata = 32'h11223344;
    ref_write(9'h05, 4'hF, 32'h11223344);
    next_cycle();
    clear_inputs();
    next_cycle();
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'b0010; wbs_adr = 32'h14; wbs_dat_w = 32'h0000AB00;
    @(negedge clk);
    n_checks++;
    if ({wbs_ack, dram_csb0, dram_web0, dram_wmask0, dram_addr0, dram_din0} !==
        {1'b0, 1'b0, 1'b0, 4'b0010, 9'h05, 32'h0000AB00}) begin
      n_fail++; $display("FAIL wb_wr_issue: got ack=%b csb=%b web=%b mask=%h addr=%h din=%h",
                         wbs_ack, dram_csb0, dram_web0, dram_wmask0, dram_addr0, dram_din0);
    end
    ref_write(9'h05, 4'b0010, 32'h0000AB00);
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({wbs_ack, wbs_dat_r, dram_csb0} !== {1'b1, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL wb_wr_ack: got ack=%b dat=%h csb=%b want 1 0 1", wbs_ack, wbs_dat_r, dram_csb0);
    end
    next_cycle();
    wbs_we = 0; wbs_sel = 4'hF; wbs_dat_w = 0;
    @(negedge clk);
    n_checks++;
    if ({wbs_ack, dram_csb0, dram_web0, dram_addr0} !== {1'b0, 1'b0, 1'b1, 9'h05}) begin
      n_fail++; $display("FAIL wb_rd_issue: got ack=%b csb=%b web=%b addr=%h want 0 0 1 5",
                         wbs_ack, dram_csb0, dram_web0, dram_addr0);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({wbs_ack, wbs_dat_r} !== {1'b1, 32'h1122AB44}) begin
      n_fail++; $display("FAIL wb_rd_data: got ack=%b dat=%h want 1 1122ab44", wbs_ack, wbs_dat_r);
    end
    clear_inputs();
    next_cycle();
  endtask

`ifdef RVJ1_DRAM_RR_EN
  task automatic test_contention();
    do_reset();
    core_req = 1; core_addr = 9'h01;
    wbs_cyc = 1; wbs_stb = 1; wbs_adr = 32'h14;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_checks++;
      if ({core_gnt, wbs_ack, dram_csb0} !== {(i % 3) != 0, (i % 3) == 1, 1'b0}) begin
        n_fail++; $display("FAIL rr_cycle%0d: got gnt=%b ack=%b csb=%b want %b %b 0",
                           i, core_gnt, wbs_ack, dram_csb0, (i % 3) != 0, (i % 3) == 1);
      end
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask
`else
  task automatic test_contention();
    core_req = 1; core_addr = 9'h01;
    wbs_cyc = 1; wbs_stb = 1; wbs_adr = 32'h14;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({core_gnt, wbs_ack} !== 2'b10) begin
        n_fail++; $display("FAIL prio_cycle%0d: got gnt=%b ack=%b want 1 0", i, core_gnt, wbs_ack);
      end
      next_cycle();
    end
    core_req = 0;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, wbs_ack, dram_csb0, dram_addr0} !== {1'b0, 1'b0, 1'b0, 9'h05}) begin
      n_fail++; $display("FAIL prio_wb_grant: got gnt=%b ack=%b csb=%b addr=%h want 0 0 0 5",
                         core_gnt, wbs_ack, dram_csb0, dram_addr0);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (wbs_ack !== 1'b1) begin
      n_fail++; $display("FAIL prio_wb_ack: got ack=%b want 1", wbs_ack);
    end
    clear_inputs();
    next_cycle();
  endtask
`endif

  task automatic test_addr_wrap();
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'hF; wbs_adr = 32'h0000_0800; wbs_dat_w = 32'hCAFEF00D;
    @(negedge clk);
    n_checks++;
    if ({dram_csb0, dram_addr0} !== {1'b0, 9'h000}) begin
      n_fail++; $display("FAIL wrap_addr: got csb=%b addr=%h want 0 000", dram_csb0, dram_addr0);
    end
    ref_write(9'h000, 4'hF, 32'hCAFEF00D);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (wbs_ack !== 1'b1) begin
      n_fail++; $display("FAIL wrap_ack: got ack=%b want 1", wbs_ack);
    end
    next_cycle();
    core_req = 1; core_addr = 9'h000;
    next_cycle();
    core_req = 0;
    @(negedge clk);
    n_checks++;
    if ({core_rvalid, core_rdata} !== {1'b1, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL wrap_read: got rv=%b rdata=%h want 1 cafef00d", core_rvalid, core_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = 32'h14;
    @(negedge clk);
    n_checks++;
    if (dram_csb0 !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_grant: got csb=%b want 0", dram_csb0);
    end
    next_cycle();
    rstn = 0;
    @(negedge clk);
    n_checks++;
    if ({wbs_ack, dram_csb0, core_rvalid} !== 3'b010) begin
      n_fail++; $display("FAIL rst_mid_drop: got ack=%b csb=%b rv=%b want 0 1 0", wbs_ack, dram_csb0, core_rvalid);
    end
    next_cycle();
    rstn = 1;
    clear_inputs();
    next_cycle();
    wbs_cyc = 1; wbs_stb = 1; wbs_adr = 32'h14;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({wbs_ack, wbs_dat_r} !== {1'b1, 32'h1122AB44}) begin
      n_fail++; $display("FAIL rst_mid_recover: got ack=%b dat=%h want 1 1122ab44", wbs_ack, wbs_dat_r);
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    logic        wb_due = 0, core_due = 0, wb_first_on_tie = 1;
    logic        win_core, win_wb, wb_want;
    logic [31:0] exp_core_rdata = 0, exp_wb_dat = 0, rnd;
    logic [8:0]  wword;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      core_req = ($urandom_range(0, 2) != 0); core_we = $urandom_range(0, 1);
      core_be = 4'($urandom()); core_addr = 9'($urandom_range(0, 15)); core_wdata = $urandom();
      wbs_cyc = ($urandom_range(0, 3) != 0); wbs_stb = ($urandom_range(0, 3) != 0);
      wbs_we = $urandom_range(0, 1); wbs_sel = 4'($urandom()); wbs_dat_w = $urandom();
      rnd = $urandom();
      wbs_adr = (rnd & 32'hFFFF_F800) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      wword = wbs_adr[10:2];
      wb_want = wbs_cyc && wbs_stb && !wb_due;
`ifdef RVJ1_DRAM_RR_EN
      if (core_req && wb_want) begin
        win_wb = wb_first_on_tie;
        wb_first_on_tie = !win_wb;
      end else win_wb = wb_want;
`else
      win_wb = wb_want && !core_req;
`endif
      win_core = core_req && !win_wb;
      @(negedge clk);
      n_checks++;
      if ({core_gnt, dram_csb0} !== {win_core, !(win_core || win_wb)}) begin
        n_fail++; $display("FAIL rnd_grant@%0d: got gnt=%b csb=%b want %b %b",
                           cyc, core_gnt, dram_csb0, win_core, !(win_core || win_wb));
      end
      if (win_core || win_wb) begin
        n_checks++;
        if (win_core ? ({dram_web0, dram_wmask0, dram_addr0, dram_din0} !==
                        {!core_we, core_we ? core_be : 4'h0, core_addr, core_wdata})
                     : ({dram_web0, dram_wmask0, dram_addr0, dram_din0} !==
                        {!wbs_we, wbs_we ? wbs_sel : 4'h0, wword, wbs_dat_w})) begin
          n_fail++; $display("FAIL rnd_drive@%0d: got web=%b mask=%h addr=%h din=%h (core won=%b)",
                             cyc, dram_web0, dram_wmask0, dram_addr0, dram_din0, win_core);
        end
      end
      n_checks++;
      if ({core_rvalid, core_rdata} !== {core_due, exp_core_rdata}) begin
        n_fail++; $display("FAIL rnd_core_rsp@%0d: got rv=%b rdata=%h want %b %h",
                           cyc, core_rvalid, core_rdata, core_due, exp_core_rdata);
      end
      n_checks++;
      if ({wbs_ack, wbs_dat_r} !== {wb_due, exp_wb_dat}) begin
        n_fail++; $display("FAIL rnd_wb_rsp@%0d: got ack=%b dat=%h want %b %h",
                           cyc, wbs_ack, wbs_dat_r, wb_due, exp_wb_dat);
      end
      core_due = win_core;
      wb_due = win_wb;
      exp_core_rdata = (win_core && !core_we) ? ref_mem[core_addr] : 32'h0;
      exp_wb_dat = (win_wb && !wbs_we) ? ref_mem[wword] : 32'h0;
      if (win_core && core_we) ref_write(core_addr, core_be, core_wdata);
      if (win_wb && wbs_we) ref_write(wword, wbs_sel, wbs_dat_w);
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_core_write_read();
    test_wb_byte_write();
    test_contention();
    test_addr_wrap();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvj1_dram_arbiter.md
# rvj1_dram_arbiter

Two-port arbiter that shares the single 1RW data SRAM macro (512 x 32, 2 KB) between the RVJ1 core data port and the Caravel Wishbone slave port. It sits in `rvj1_caravel_soc`, between the core LSU and Wishbone address decoder on one side and the `dram_*` macro pins on the other. It grants one access per cycle, drives the macro's active-low controls, and returns read data with the macro's one-cycle latency.

## Interface
Parameters:
- `ADDR_W`, 9: SRAM word-address width (512 words).

Ports:
- `wb_clk_i` in 1: single clock for the block and the macro.
- `rstn_i` in 1: reset, asynchronous and active-low.
- `core_req_i` in 1: core access request.
- `core_we_i` in 1: 1 = write.
- `core_be_i` in 4: byte enables.
- `core_addr_i` in ADDR_W: word address.
- `core_wdata_i` in 32: write data.
- `core_gnt_o` out 1: request accepted this cycle (combinational).
- `core_rvalid_o` out 1: response for the access granted last cycle.
- `core_rdata_o` out 32: read data; valid with `core_rvalid_o` on reads.
- `wbs_cyc_i`, `wbs_stb_i` in 1: Wishbone cycle/strobe, already decoded to the DRAM region.
- `wbs_we_i` in 1: Wishbone write enable.
- `wbs_sel_i` in 4: Wishbone byte selects.
- `wbs_adr_i` in 32: byte address; bits [ADDR_W+1:2] are used.
- `wbs_dat_i` in 32: Wishbone write data.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `wbs_dat_o` out 32: read data, qualified by `wbs_ack_o`.
- `dram_csb0` out 1: macro chip select, active-low.
- `dram_web0` out 1: macro write enable, active-low.
- `dram_wmask0` out 4: macro write mask.
- `dram_addr0` out ADDR_W: macro address.
- `dram_din0` out 32: macro write data.
- `dram_dout0` in 32: macro read data, valid the cycle after the access.

## Operation
- Wishbone request is `wb_req = wbs_cyc_i & wbs_stb_i & (wb_state == WB_IDLE)`.
- Per-cycle grant, at most one winner:
  - core only requesting: core wins.
  - WB only requesting: WB wins.
  - both requesting: resolved by the arbitration policy (see Configuration).
- Macro drive in the grant cycle (combinational from the winner):
  - `dram_csb0 = 0`.
  - `dram_web0 = ~we`.
  - `dram_wmask0` = be/sel on writes, 4'h0 on reads.
  - `dram_addr0`, `dram_din0` from the winner.
- Macro drive with no grant: `csb0 = 1`, `web0 = 1`, `wmask0`/`addr0`/`din0` all zero.
- Core port:
  - `core_gnt_o` is high in the grant cycle.
  - `core_rvalid_o` is high exactly one cycle later, for both reads and writes.
  - `core_rdata_o = dram_dout0` on read responses, 32'h0 otherwise.
- WB FSM: two states, `WB_IDLE` and `WB_ACK`.
  - `WB_IDLE` → `WB_ACK` when WB is granted.
  - `WB_ACK` → `WB_IDLE` unconditionally.
  - In `WB_ACK`: `wbs_ack_o = 1`; `wbs_dat_o = dram_dout0` for a read, 32'h0 for a write.
  - WB is never granted in `WB_ACK`, so the same strobe is not issued twice.
  - The core may be granted during `WB_ACK`.
- Registered state: `wb_state`, `core_rvalid_q`, `core_rd_q`, `wb_rd_q`, `last_wb` (RR only).
- Dropping `wbs_cyc_i` during `WB_ACK` does not cancel the ack; the access has already been issued.

## Timing
- Reset values (`rstn_i` = 0, asynchronous):
  - `wb_state = WB_IDLE`.
  - `core_rvalid_o = 0`, `wbs_ack_o = 0`.
  - `core_rdata_o = 0`, `wbs_dat_o = 0`.
  - `dram_csb0 = 1`, `dram_web0 = 1`, all other `dram_*` = 0.
  - `core_gnt_o = 0`.
  - `last_wb = 0`.
- Core latency: gnt at cycle N, rvalid/rdata at N+1. Back-to-back grants give 1 access/cycle.
- WB latency: stb seen and granted at cycle N, ack at N+1. Maximum WB throughput is 1 access / 2 cycles.
- Reset asserted mid-access: pending rvalid/ack are dropped and never emitted; the SRAM write may or may not have happened.
- Address wrap: only the low ADDR_W word bits are used; higher address bits are ignored (no error response).

## Configuration
- `RVJ1_DRAM_RR_EN` defined: round-robin arbitration on contention.
  - Winner = WB if `last_wb == 0`, else core.
  - `last_wb` updates on every contended grant (1 if WB won).
  - Neither port waits more than one contended grant.
- `RVJ1_DRAM_RR_EN` undefined: fixed priority, core always wins. WB may starve under continuous core requests. `last_wb` is not implemented.

## Test plan
- Core write then read: write addr 9'h05 = 32'hDEADBEEF with be 4'hF, then read 9'h05.
  - Expect gnt in each request cycle, rvalid the next cycle, rdata 32'hDEADBEEF.
- WB byte write then read:
  - sel 4'b0010, adr 32'h0000_0014, dat 32'h0000_AB00 over an existing 32'h11223344; ack 1 cycle after stb.
  - Read of adr 32'h14 acks with 32'h1122AB44.
- Contention, RR enabled: core and WB both request continuously from reset.
  - Grants go WB, core, core(WB in ACK), WB, ...; each WB ack follows its grant by one cycle.
- Contention, RR disabled: core requests every cycle for 20 cycles while WB holds stb.
  - No `wbs_ack_o` until core drops req; WB acks one cycle after that.
- Address wrap: WB write at adr 32'h0000_0800 (word 512).
  - Lands at word 0; a core read of 9'h000 returns the written data.
- Reset mid-access: assert `rstn_i` = 0 in the cycle after a WB read grant.
  - `wbs_ack_o` stays 0, `dram_csb0` = 1 immediately.
  - After release, a new WB read completes normally.
